lif_spike_monitor: RTL and testbench
====================================

# lif_spike_monitor

Downstream observer for the LIF neuron's `spike` output. It measures two things on one spike train: the firing rate, as spikes per programmable window, and the inter-spike interval (ISI), in clock cycles. Results are latched into registers with one-cycle valid strobes, so a neighbouring neuron, a readout mux or the bidirectional IO bank can consume them. It sits directly after the neuron, fed by its spike bit, in the same clock domain.

## Interface
- `WIN_W`, default 8: width of the window-length control and the window counter.
- `CNT_W`, default 8: width of the spike counter and `rate_out`.
- `ISI_W`, default 8: width of the ISI counter and `isi_out`.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: count enable. While low, counters freeze and spikes are ignored.
- `spike_in` input 1: spike from the neuron, sampled every enabled edge.
- `clear` input 1: synchronous clear of counters; has priority over counting.
- `window_len` input `WIN_W`: window length minus one, so the window is `window_len+1` enabled cycles.
- `rate_out` output `CNT_W`: spike count of the last completed window, saturating.
- `rate_valid` output 1: one-cycle strobe when `rate_out` updates.
- `rate_sat` output 1: set if the last completed window saturated.
- `isi_out` output `ISI_W`: last measured ISI, saturating.
- `isi_valid` output 1: one-cycle strobe when `isi_out` updates.

## Operation
- **Reset values.** All outputs 0, all counters 0, window FSM in `IDLE`, ISI `armed`=0.
- **Window FSM states.** `IDLE` → `RUN` on the first enabled edge, which latches `window_len` into `win_len_q`. `RUN` stays in `RUN`.
- **Window counting.** `win_cnt` counts enabled edges from 0 to `win_len_q`. On the terminal edge (`win_cnt==win_len_q`):
  - `rate_out` takes the count plus the current `spike_in`, saturated at 2^CNT_W−1.
  - `rate_sat` takes the saturation flag.
  - `rate_valid` is set to 1.
  - `spk_cnt` and `win_cnt` return to 0.
  - `win_len_q` re-latches `window_len`.
- **Window-length changes.** A change to `window_len` mid-window takes effect only at the next window boundary. `window_len`=0 gives a one-cycle window, so `rate_out` equals `spike_in` every edge.
- **Spike counter.** Increments on each sampled spike and holds at 2^CNT_W−1. An internal sticky flag records the hold.
- **ISI counter.**
  - `isi_cnt` increments every enabled edge and holds at 2^ISI_W−1.
  - On a sampled spike with `armed`=1: `isi_out` takes `isi_cnt`+1, saturated; `isi_valid` is set to 1; `isi_cnt` returns to 0.
  - On the first spike with `armed`=0: `isi_cnt` returns to 0 and `armed` is set to 1. There is no strobe.
  - Spikes on consecutive enabled edges give an ISI of 1.
- **`ena` low.** All counters, `armed` and the FSM hold. Strobes are 0. Disabled cycles are not counted in the window or the ISI.
- **`clear`.** `spk_cnt`, `win_cnt` and `isi_cnt` go to 0, `armed` goes to 0, and the FSM goes to `IDLE`. `rate_out`, `isi_out` and `rate_sat` keep their values. The strobes are 0 that cycle. A spike on the `clear` cycle is discarded.
- **Simultaneous events.** A spike on the window terminal edge counts in the closing window. The rate and ISI strobes may assert on the same cycle.
- **Reset mid-operation.** Asynchronous: outputs return to reset values immediately. Counting restarts on the first enabled edge after `rst_n` rises.

## Timing
- All outputs are registered.
- The strobes are high for exactly the cycle following the updating edge.
- Latency:
  - Spike to `isi_valid`: 1 cycle.
  - Terminal window edge to `rate_valid`: 1 cycle.
- Strobes are never held for more than one cycle. There is no backpressure, so a consumer must capture on the strobe.

## Structure
- Shared package `snn_pkg`:
  - default widths `SNN_CNT_W`=8 and `SNN_ISI_W`=8;
  - window FSM state enum `win_state_t` {`IDLE`, `RUN`};
  - saturation helper function `sat_inc`.
- One natural sub-module, `sat_counter` (parameterised width, enable, synchronous clear, saturating increment, at-max flag). It is instantiated for `spk_cnt` and `isi_cnt`.
- The window counter, FSM and output registers live in the top of this block.

## Test plan
- **Spike every cycle.** `window_len`=3, `ena`=1, `spike_in`=1 constantly → `rate_out`=4 and `rate_valid` pulses every 4th cycle; `isi_out`=1 with `isi_valid` every cycle after the first spike.
- **First ISI.** Spikes at enabled edges 2 and 7 only → no strobe at edge 2; `isi_out`=5 with one `isi_valid` after edge 7; the window of 8 reports 2.
- **Rate saturation.** `window_len`=255, `spike_in`=1 constantly → `rate_out`=255 and `rate_sat`=1 at each window end. Then `spike_in`=0 for one window → `rate_out`=0, `rate_sat`=0.
- **ISI saturation.** Spike, 300 idle cycles, spike → `isi_out`=255 with one `isi_valid`.
- **`ena` low.** `window_len`=7, `ena` low for 10 cycles mid-window with spikes applied → those spikes are ignored and `rate_valid` is delayed by exactly 10 cycles.
- **`clear` and reset mid-window.**
  - `clear` mid-window → next `rate_valid` comes `window_len+1` enabled cycles after `clear`; the next spike only arms the ISI.
  - `rst_n` low mid-window → all outputs read 0 before the next clock edge.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron datapath: default widths,
// the window FSM state type and a saturating increment helper.
package snn_pkg;

   localparam int SNN_CNT_W = 8;
   localparam int SNN_ISI_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } win_state_t;

   // Increments val by one if inc is set, holding at 2^width-1 (width < 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                           input logic inc,
                                           input int unsigned width);
      logic [31:0] max_val;
      max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      if (inc && (val < max_val)) begin
         return val + 32'd1;
      end
      return val;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear; clear beats enable.
// Count is registered (visible one cycle after the edge); no backpressure.
module sat_counter
   import snn_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt,
   output logic         at_max
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = W'(sat_inc(32'(cnt_q), inc, W));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt    = cnt_q;
   assign at_max = (cnt_q == {W{1'b1}});

endmodule

// File: rtl/lif_spike_monitor.sv
// Measures spike rate per programmable window and inter-spike interval of one spike train.
// Results registered with single-cycle strobes one cycle after the edge; no backpressure.
module lif_spike_monitor
   import snn_pkg::*;
#(
   parameter int WIN_W = 8,
   parameter int CNT_W = SNN_CNT_W,
   parameter int ISI_W = SNN_ISI_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             spike_in,
   input  logic             clear,
   input  logic [WIN_W-1:0] window_len,
   output logic [CNT_W-1:0] rate_out,
   output logic             rate_valid,
   output logic             rate_sat,
   output logic [ISI_W-1:0] isi_out,
   output logic             isi_valid
);

   win_state_t       state_q, state_d;
   logic [WIN_W-1:0] win_len_q, win_len_d;
   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   logic             sat_sticky_q, sat_sticky_d;
   logic             armed_q, armed_d;
   logic [CNT_W-1:0] rate_out_q, rate_out_d;
   logic             rate_valid_q, rate_valid_d;
   logic             rate_sat_q, rate_sat_d;
   logic [ISI_W-1:0] isi_out_q, isi_out_d;
   logic             isi_valid_q, isi_valid_d;

   logic [CNT_W-1:0] spk_cnt;
   logic             spk_at_max;
   logic             spk_en, spk_clr;
   logic [ISI_W-1:0] isi_cnt;
   logic             isi_at_max;
   logic             isi_en, isi_clr;
   logic [WIN_W-1:0] cur_len;
   logic             terminal;

   sat_counter #(.W(CNT_W)) u_spk_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (spk_en),
      .clr    (spk_clr),
      .inc    (spike_in),
      .cnt    (spk_cnt),
      .at_max (spk_at_max)
   );

   sat_counter #(.W(ISI_W)) u_isi_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (isi_en),
      .clr    (isi_clr),
      .inc    (1'b1),
      .cnt    (isi_cnt),
      .at_max (isi_at_max)
   );

   always_comb begin
      state_d      = state_q;
      win_len_d    = win_len_q;
      win_cnt_d    = win_cnt_q;
      sat_sticky_d = sat_sticky_q;
      armed_d      = armed_q;
      rate_out_d   = rate_out_q;
      rate_sat_d   = rate_sat_q;
      isi_out_d    = isi_out_q;
      rate_valid_d = 1'b0;
      isi_valid_d  = 1'b0;
      spk_en       = 1'b0;
      spk_clr      = 1'b0;
      isi_en       = 1'b0;
      isi_clr      = 1'b0;
      // The first edge of a fresh window uses the live length it is latching.
      cur_len      = (state_q == IDLE) ? window_len : win_len_q;
      terminal     = (win_cnt_q == cur_len);

      if (clear) begin
         state_d      = IDLE;
         win_cnt_d    = '0;
         sat_sticky_d = 1'b0;
         armed_d      = 1'b0;
         spk_clr      = 1'b1;
         isi_clr      = 1'b1;
      end else if (ena) begin
         if (state_q == IDLE) begin
            state_d   = RUN;
            win_len_d = window_len;
         end

         if (terminal) begin
            rate_out_d   = CNT_W'(sat_inc(32'(spk_cnt), spike_in, CNT_W));
            rate_sat_d   = sat_sticky_q | (spk_at_max & spike_in);
            rate_valid_d = 1'b1;
            win_cnt_d    = '0;
            win_len_d    = window_len;
            sat_sticky_d = 1'b0;
            spk_clr      = 1'b1;
         end else begin
            win_cnt_d    = win_cnt_q + WIN_W'(1);
            sat_sticky_d = sat_sticky_q | (spk_at_max & spike_in);
            spk_en       = 1'b1;
         end

         if (spike_in) begin
            isi_clr = 1'b1;
            if (armed_q) begin
               isi_out_d   = isi_at_max ? isi_cnt : (isi_cnt + ISI_W'(1));
               isi_valid_d = 1'b1;
            end else begin
               armed_d = 1'b1;
            end
         end else begin
            isi_en = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         win_len_q    <= '0;
         win_cnt_q    <= '0;
         sat_sticky_q <= 1'b0;
         armed_q      <= 1'b0;
         rate_out_q   <= '0;
         rate_valid_q <= 1'b0;
         rate_sat_q   <= 1'b0;
         isi_out_q    <= '0;
         isi_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         win_len_q    <= win_len_d;
         win_cnt_q    <= win_cnt_d;
         sat_sticky_q <= sat_sticky_d;
         armed_q      <= armed_d;
         rate_out_q   <= rate_out_d;
         rate_valid_q <= rate_valid_d;
         rate_sat_q   <= rate_sat_d;
         isi_out_q    <= isi_out_d;
         isi_valid_q  <= isi_valid_d;
      end
   end

   assign rate_out   = rate_out_q;
   assign rate_valid = rate_valid_q;
   assign rate_sat   = rate_sat_q;
   assign isi_out    = isi_out_q;
   assign isi_valid  = isi_valid_q;

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Directed bench for lif_spike_monitor: inputs change and outputs are sampled on the falling edge.
module tb_lif_spike_monitor;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       spike_in;
   logic       clear;
   logic [7:0] window_len;
   logic [7:0] rate_out;
   logic       rate_valid;
   logic       rate_sat;
   logic [7:0] isi_out;
   logic       isi_valid;

   int n_checks = 0;
   int n_errors = 0;
   int nstb;
   logic [3:0] pat;

   lif_spike_monitor dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .spike_in   (spike_in),
      .clear      (clear),
      .window_len (window_len),
      .rate_out   (rate_out),
      .rate_valid (rate_valid),
      .rate_sat   (rate_sat),
      .isi_out    (isi_out),
      .isi_valid  (isi_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      ena        = 1'b0;
      spike_in   = 1'b0;
      clear      = 1'b0;
      window_len = 8'd3;
      #1;
      chk8("reset_rate_out", rate_out, 8'd0);
      chk1("reset_rate_valid", rate_valid, 1'b0);
      chk1("reset_rate_sat", rate_sat, 1'b0);
      chk8("reset_isi_out", isi_out, 8'd0);
      chk1("reset_isi_valid", isi_valid, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;

      // Spike every cycle, 4-cycle windows.
      ena      = 1'b1;
      spike_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk1("every_rate_valid", rate_valid, (i % 4 == 3));
         chk1("every_isi_valid", isi_valid, (i != 0));
         if (i % 4 == 3) chk8("every_rate_out", rate_out, 8'd4);
         if (i > 0) chk8("every_isi_out", isi_out, 8'd1);
      end

      // Clear keeps results, suppresses strobes.
      spike_in = 1'b0;
      clear    = 1'b1;
      tick();
      chk1("clr1_rate_valid", rate_valid, 1'b0);
      chk1("clr1_isi_valid", isi_valid, 1'b0);
      chk8("clr1_rate_hold", rate_out, 8'd4);
      clear = 1'b0;

      // First ISI: spikes at enabled edges 2 and 7 of an 8-cycle window.
      window_len = 8'd7;
      for (int i = 0; i < 8; i++) begin
         spike_in = (i == 2) || (i == 7);
         tick();
         if (i == 2) chk1("first_spike_no_strobe", isi_valid, 1'b0);
         if (i < 7) chk1("first_rate_valid_early", rate_valid, 1'b0);
      end
      chk1("first_isi_valid", isi_valid, 1'b1);
      chk8("first_isi_out", isi_out, 8'd5);
      chk1("first_rate_valid", rate_valid, 1'b1);
      chk8("first_rate_out", rate_out, 8'd2);
      chk1("first_rate_sat", rate_sat, 1'b0);

      // ena low for 10 cycles mid-window; window_len change deferred.
      window_len = 8'd1;
      for (int i = 0; i < 4; i++) begin
         spike_in = (i == 3);
         tick();
         chk1("ena_rate_valid_pre", rate_valid, 1'b0);
      end
      chk1("ena_isi_valid_pre", isi_valid, 1'b1);
      chk8("ena_isi_out_pre", isi_out, 8'd4);
      ena      = 1'b0;
      spike_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk1("ena_low_rate_valid", rate_valid, 1'b0);
         chk1("ena_low_isi_valid", isi_valid, 1'b0);
      end
      ena = 1'b1;
      for (int i = 4; i < 8; i++) begin
         spike_in = (i == 7);
         tick();
         chk1("ena_rate_valid_post", rate_valid, (i == 7));
      end
      chk8("ena_rate_out", rate_out, 8'd2);
      chk1("ena_isi_valid", isi_valid, 1'b1);
      chk8("ena_isi_out", isi_out, 8'd4);

      // Two-cycle window from the deferred length, then one-cycle windows.
      spike_in   = 1'b1;
      window_len = 8'd0;
      tick();
      chk1("len2_rate_valid_e0", rate_valid, 1'b0);
      tick();
      chk1("len2_rate_valid_e1", rate_valid, 1'b1);
      chk8("len2_rate_out", rate_out, 8'd2);
      pat = 4'b0110;
      for (int i = 0; i < 4; i++) begin
         spike_in = pat[i];
         tick();
         chk1("len1_rate_valid", rate_valid, 1'b1);
         chk8("len1_rate_out", rate_out, {7'd0, pat[i]});
      end

      // Rate saturation with 256-cycle windows.
      window_len = 8'd255;
      spike_in   = 1'b0;
      tick();
      chk1("sat_latch_rate_valid", rate_valid, 1'b1);
      chk8("sat_latch_rate_out", rate_out, 8'd0);
      spike_in = 1'b1;
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 256; i++) begin
            tick();
            if (i == 254) chk1("sat_rate_valid_early", rate_valid, 1'b0);
         end
         chk1("sat_rate_valid", rate_valid, 1'b1);
         chk8("sat_rate_out", rate_out, 8'd255);
         chk1("sat_rate_sat", rate_sat, 1'b1);
      end
      chk8("sat_isi_out", isi_out, 8'd1);
      spike_in = 1'b0;
      repeat (256) tick();
      chk1("unsat_rate_valid", rate_valid, 1'b1);
      chk8("unsat_rate_out", rate_out, 8'd0);
      chk1("unsat_rate_sat", rate_sat, 1'b0);

      // ISI saturation: spike, 300 idle cycles, spike.
      spike_in = 1'b1;
      tick();
      chk1("isisat_first_valid", isi_valid, 1'b1);
      chk8("isisat_first_out", isi_out, 8'd255);
      spike_in = 1'b0;
      nstb     = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (isi_valid) nstb++;
      end
      chk8("isisat_idle_strobes", (nstb > 255) ? 8'd255 : 8'(nstb), 8'd0);
      spike_in = 1'b1;
      tick();
      chk1("isisat_valid", isi_valid, 1'b1);
      chk8("isisat_out", isi_out, 8'd255);

      // Clear mid-window with a spike on the clear cycle.
      window_len = 8'd3;
      clear      = 1'b1;
      tick();
      chk1("clr2_rate_valid", rate_valid, 1'b0);
      chk1("clr2_isi_valid", isi_valid, 1'b0);
      chk8("clr2_rate_hold", rate_out, 8'd1);
      chk8("clr2_isi_hold", isi_out, 8'd255);
      chk1("clr2_sat_hold", rate_sat, 1'b0);
      clear = 1'b0;
      for (int i = 0; i < 4; i++) begin
         spike_in = (i == 1) || (i == 3);
         tick();
         chk1("clr2_win_rate_valid", rate_valid, (i == 3));
         chk1("clr2_win_isi_valid", isi_valid, (i == 3));
      end
      chk8("clr2_rate_out", rate_out, 8'd2);
      chk8("clr2_isi_out", isi_out, 8'd2);

      // Asynchronous reset while strobes are high.
      rst_n = 1'b0;
      #1;
      chk8("arst_rate_out", rate_out, 8'd0);
      chk1("arst_rate_valid", rate_valid, 1'b0);
      chk1("arst_rate_sat", rate_sat, 1'b0);
      chk8("arst_isi_out", isi_out, 8'd0);
      chk1("arst_isi_valid", isi_valid, 1'b0);
      tick();
      rst_n      = 1'b1;
      window_len = 8'd0;
      spike_in   = 1'b1;
      tick();
      chk1("post_rst_rate_valid", rate_valid, 1'b1);
      chk8("post_rst_rate_out", rate_out, 8'd1);
      chk1("post_rst_isi_valid", isi_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
